regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised register file for the pipelined datapath, replacing the fixed 8x16 file. It provides two combinational read ports and one write port. It adds asynchronous clearing, same-cycle write-to-read bypass, an optional hardwired-zero R0, and a per-register busy scoreboard. The pipeline's decode stage uses the scoreboard for hazard detection: issue sets busy, writeback clears it.

Parameters:
WIDTH, 16, data width of each register.
NREGS, 8, number of registers; need not be a power of two.
AW, $clog2(NREGS), register index width; derived, never overridden.
BYPASS, 1, 1 = a read of the register being written this cycle returns data_in.
ZERO_R0, 0, 1 = R0 always reads 0, ignores writes, never goes busy.

Ports:
clk  in  1  clock; all state updates on posedge.
reset_n  in  1  asynchronous active-low reset.
data_in  in  WIDTH  writeback data.
writenum  in  AW  writeback register index.
write  in  1  writeback enable.
readA  in  AW  read port A index.
readB  in  AW  read port B index.
A_out  out  WIDTH  port A data, combinational.
B_out  out  WIDTH  port B data, combinational.
issue  in  1  decode issued an instruction that will write issue_num.
issue_num  in  AW  destination index of the issued instruction.
busyA  out  1  readA operand not yet available.
busyB  out  1  readB operand not yet available.
busy_vec  out  NREGS  raw scoreboard, bit i = register i busy.
waw_err  out  1  sticky: issue to an already-busy register.

Behaviour:
- Reset (reset_n=0, asynchronous): all registers 0, busy_vec 0, waw_err 0. A_out, B_out, busyA and busyB follow from the cleared state, so they are 0 while reset is held. Reset beats any write or issue in the same cycle.
- Write: at posedge, if write=1 and writenum<NREGS, the register takes data_in. Write latency is 1 cycle.
- Writes to index >=NREGS are ignored. Under ZERO_R0=1, writes to index 0 are ignored.
- Read: A_out = reg[readA] and B_out = reg[readB], purely combinational with no clock latency. An index >=NREGS reads 0. Under ZERO_R0=1, index 0 reads 0.
- Bypass (BYPASS=1): if write=1 and writenum==readA, A_out = data_in in the same cycle. The same rule applies to B. Bypass never applies to an ignored write (out of range, or R0 under ZERO_R0).
- Bypass off (BYPASS=0): a read returns the old value until the next posedge.
- Scoreboard update at posedge:
  - If write=1 (valid index), clear busy[writenum].
  - If issue=1 (valid index, not R0 under ZERO_R0), set busy[issue_num].
  - If both hit the same index in the same cycle, set wins and the register stays busy; the new producer owns it.
- WAW error: if issue=1 and busy[issue_num]=1 before the edge, and the register is not being cleared by a write that same cycle, set waw_err at that edge. waw_err holds until reset.
- busyA = busy[readA] AND NOT (BYPASS AND write AND writenum==readA). busyA is 0 for an invalid index and for R0 under ZERO_R0. busyB follows the same rule.
- Issue and write of different indices in the same cycle are fully independent.
- No other state. An issue does not modify register contents.

Test Plan:
- Reset then read: assert reset_n=0 mid-run after writing R3=16'h1234 -> A_out with readA=3 returns 16'h0000 immediately; busy_vec=0; waw_err=0.
- Write/read all: write R0..R7 with 16'hA000+i, then read pairs (i, 7-i) -> A_out=16'hA000+i, B_out=16'hA007-i; R0 reads 16'h0000 when ZERO_R0=1.
- Bypass: R5=16'h0011; same cycle write=1, writenum=5, data_in=16'h00FF, readA=5 -> A_out=16'h00FF before the edge with BYPASS=1, and 16'h0011 with BYPASS=0.
- Scoreboard: issue R2 -> busy_vec=8'b0000_0100 next cycle, busyA=1 for readA=2. Then write R2 with readA=2 -> busyA=0 that cycle (BYPASS=1), busy_vec=0 after the edge.
- Simultaneous issue+write to R4 while busy -> R4 stays busy, waw_err stays 0. A second issue to R4 with no write -> waw_err=1 next edge and it holds.
- Parametrised: WIDTH=32, NREGS=6; write index 6 with 32'hDEADBEEF -> ignored; read index 6 returns 0; issue index 7 -> busy_vec unchanged.

Source files
------------

// File: rtl/regfile_sb.sv
// Parametrised register file with two combinational read ports, one write
// port, same-cycle bypass, optional hardwired-zero R0 and a busy scoreboard.
module regfile_sb #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned NREGS   = 8,
    parameter bit          BYPASS  = 1'b1,
    parameter bit          ZERO_R0 = 1'b0,
    localparam int unsigned AW     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic [AW-1:0]    writenum,
    input  logic             write,
    input  logic [AW-1:0]    readA,
    input  logic [AW-1:0]    readB,
    output logic [WIDTH-1:0] A_out,
    output logic [WIDTH-1:0] B_out,
    input  logic             issue,
    input  logic [AW-1:0]    issue_num,
    output logic             busyA,
    output logic             busyB,
    output logic [NREGS-1:0] busy_vec,
    output logic             waw_err
);

    logic [WIDTH-1:0] regs_q [NREGS];
    logic [WIDTH-1:0] regs_d [NREGS];
    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             waw_q;
    logic             waw_d;

    logic             wr_ok;
    logic             iss_ok;

    // An index is usable if it is in range and is not a hardwired R0.
    function automatic logic idx_ok(input logic [AW-1:0] idx);
        return (32'(idx) < NREGS) && !(ZERO_R0 && (idx == '0));
    endfunction

    // Qualify write and issue; ignored writes also never bypass.
    always_comb begin
        wr_ok  = write && idx_ok(writenum);
        iss_ok = issue && idx_ok(issue_num);
    end

    // Next-state for data, scoreboard and the sticky WAW flag.
    always_comb begin
        busy_d = busy_q;
        waw_d  = waw_q;
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
            if (wr_ok && (writenum == AW'(i))) begin
                regs_d[i] = data_in;
                busy_d[i] = 1'b0;
            end
        end
        for (int i = 0; i < NREGS; i++) begin
            if (iss_ok && (issue_num == AW'(i))) begin
                busy_d[i] = 1'b1;
                if (busy_q[i] && !(wr_ok && (writenum == AW'(i)))) begin
                    waw_d = 1'b1;
                end
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
            busy_q <= '0;
            waw_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q <= busy_d;
            waw_q  <= waw_d;
        end
    end

    // Combinational read muxes with optional write-data bypass.
    always_comb begin
        A_out = '0;
        B_out = '0;
        busyA = 1'b0;
        busyB = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            if (readA == AW'(i)) begin
                A_out = regs_q[i];
                busyA = busy_q[i];
            end
            if (readB == AW'(i)) begin
                B_out = regs_q[i];
                busyB = busy_q[i];
            end
        end
        if (!idx_ok(readA)) begin
            A_out = '0;
            busyA = 1'b0;
        end
        if (!idx_ok(readB)) begin
            B_out = '0;
            busyB = 1'b0;
        end
        if (BYPASS && wr_ok && (writenum == readA)) begin
            A_out = data_in;
            busyA = 1'b0;
        end
        if (BYPASS && wr_ok && (writenum == readB)) begin
            B_out = data_in;
            busyB = 1'b0;
        end
    end

    assign busy_vec = busy_q;
    assign waw_err  = waw_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb across three configurations:
// default, no-bypass with zero R0, and a 32-bit six-entry file.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        reset_n;

    logic [15:0] data_in;
    logic [2:0]  writenum;
    logic        write;
    logic [2:0]  readA;
    logic [2:0]  readB;
    logic        issue;
    logic [2:0]  issue_num;

    logic [15:0] a0, b0, a1, b1;
    logic        ba0, bb0, ba1, bb1;
    logic [7:0]  bv0, bv1;
    logic        w0, w1;

    logic [31:0] p_data;
    logic [2:0]  p_wnum;
    logic        p_write;
    logic [2:0]  p_ra;
    logic [2:0]  p_rb;
    logic        p_issue;
    logic [2:0]  p_inum;
    logic [31:0] p_a, p_b;
    logic        p_ba, p_bb;
    logic [5:0]  p_bv;
    logic        p_w;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk(clk), .reset_n(reset_n), .data_in(data_in),
        .writenum(writenum), .write(write), .readA(readA), .readB(readB),
        .A_out(a0), .B_out(b0), .issue(issue), .issue_num(issue_num),
        .busyA(ba0), .busyB(bb0), .busy_vec(bv0), .waw_err(w0)
    );

    regfile_sb #(.BYPASS(1'b0), .ZERO_R0(1'b1)) dut_z (
        .clk(clk), .reset_n(reset_n), .data_in(data_in),
        .writenum(writenum), .write(write), .readA(readA), .readB(readB),
        .A_out(a1), .B_out(b1), .issue(issue), .issue_num(issue_num),
        .busyA(ba1), .busyB(bb1), .busy_vec(bv1), .waw_err(w1)
    );

    regfile_sb #(.WIDTH(32), .NREGS(6)) dut_p (
        .clk(clk), .reset_n(reset_n), .data_in(p_data),
        .writenum(p_wnum), .write(p_write), .readA(p_ra), .readB(p_rb),
        .A_out(p_a), .B_out(p_b), .issue(p_issue), .issue_num(p_inum),
        .busyA(p_ba), .busyB(p_bb), .busy_vec(p_bv), .waw_err(p_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        data_in = '0; writenum = '0; write = 1'b0;
        readA = '0; readB = '0; issue = 1'b0; issue_num = '0;
        p_data = '0; p_wnum = '0; p_write = 1'b0;
        p_ra = '0; p_rb = '0; p_issue = 1'b0; p_inum = '0;
        #1;
        chk("rst_A", 32'(a0), 32'h0);
        chk("rst_busy", 32'(bv0), 32'h0);
        chk("rst_waw", 32'(w0), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // R3 = 1234 while also issuing R3: set wins over clear
        tick();
        write = 1'b1; writenum = 3'd3; data_in = 16'h1234;
        issue = 1'b1; issue_num = 3'd3;
        tick();
        write = 1'b0; issue = 1'b0; readA = 3'd3;
        #1;
        chk("wr_r3", 32'(a0), 32'h1234);
        chk("busy_r3", 32'(bv0), 32'h08);
        reset_n = 1'b0;
        #1;
        chk("midrst_A", 32'(a0), 32'h0);
        chk("midrst_busy", 32'(bv0), 32'h0);
        chk("midrst_waw", 32'(w0), 32'h0);
        chk("midrst_busyA", 32'(ba0), 32'h0);
        reset_n = 1'b1;

        // Write all registers
        for (int i = 0; i < 8; i++) begin
            tick();
            write = 1'b1; writenum = 3'(i); data_in = 16'hA000 + 16'(i);
        end
        tick();
        write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            readA = 3'(i); readB = 3'(7 - i);
            #1;
            chk("rd_A", 32'(a0), 32'hA000 + 32'(i));
            chk("rd_B", 32'(b0), 32'hA007 - 32'(i));
            chk("rdz_A", 32'(a1), (i == 0) ? 32'h0 : 32'hA000 + 32'(i));
            chk("rdz_B", 32'(b1), 32'hA007 - 32'(i));
        end

        // Bypass on vs off
        tick();
        write = 1'b1; writenum = 3'd5; data_in = 16'h0011;
        tick();
        data_in = 16'h00FF; readA = 3'd5;
        #1;
        chk("byp_on", 32'(a0), 32'h00FF);
        chk("byp_off", 32'(a1), 32'h0011);
        tick();
        write = 1'b0;
        #1;
        chk("byp_on_post", 32'(a0), 32'h00FF);
        chk("byp_off_post", 32'(a1), 32'h00FF);

        // Scoreboard issue / writeback
        issue = 1'b1; issue_num = 3'd2;
        tick();
        issue = 1'b0; readA = 3'd2;
        #1;
        chk("sb_vec", 32'(bv0), 32'h04);
        chk("sb_busyA", 32'(ba0), 32'h1);
        chk("sbz_vec", 32'(bv1), 32'h04);
        chk("sbz_busyA", 32'(ba1), 32'h1);
        write = 1'b1; writenum = 3'd2; data_in = 16'h2222;
        #1;
        chk("sb_wb_busyA", 32'(ba0), 32'h0);
        chk("sbz_wb_busyA", 32'(ba1), 32'h1);
        tick();
        write = 1'b0;
        #1;
        chk("sb_clr", 32'(bv0), 32'h0);
        chk("sbz_clr", 32'(bv1), 32'h0);

        // WAW: issue+write same index keeps busy without error
        issue = 1'b1; issue_num = 3'd4;
        tick();
        write = 1'b1; writenum = 3'd4; data_in = 16'h4444;
        tick();
        write = 1'b0;
        #1;
        chk("iw_vec", 32'(bv0), 32'h10);
        chk("iw_waw", 32'(w0), 32'h0);
        tick();
        issue = 1'b0;
        #1;
        chk("waw_set", 32'(w0), 32'h1);
        tick();
        #1;
        chk("waw_hold", 32'(w0), 32'h1);

        // R0 issue and write under ZERO_R0
        issue = 1'b1; issue_num = 3'd0;
        write = 1'b1; writenum = 3'd0; data_in = 16'h5555;
        tick();
        issue = 1'b0; write = 1'b0; readA = 3'd0;
        #1;
        chk("r0_vec", 32'(bv0), 32'h11);
        chk("r0z_vec", 32'(bv1), 32'h10);
        chk("r0z_rd", 32'(a1), 32'h0);
        chk("r0_rd", 32'(a0), 32'h5555);

        // 32-bit, 6-entry configuration
        p_write = 1'b1; p_wnum = 3'd6; p_data = 32'hDEADBEEF; p_ra = 3'd6;
        #1;
        chk("p_oor_byp", p_a, 32'h0);
        tick();
        p_wnum = 3'd5; p_data = 32'hCAFEF00D;
        #1;
        chk("p_oor_rd", p_a, 32'h0);
        tick();
        p_write = 1'b0; p_rb = 3'd5;
        p_issue = 1'b1; p_inum = 3'd7;
        #1;
        chk("p_rd5", p_b, 32'hCAFEF00D);
        tick();
        p_issue = 1'b0;
        #1;
        chk("p_oor_issue", 32'(p_bv), 32'h0);
        chk("p_waw", 32'(p_w), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
